// File: rtl/nco_phase_gen.sv
// Numerically controlled oscillator phase generator: accumulator, offset/dither
// stage and sin/cos ROM address stage, with valid/wrap flags pipelined alongside.
module nco_phase_gen #(
  parameter int PHASE_W   = 32,
  parameter int ADDR_W    = 12,
  parameter int DITHER_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_wr,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic               phase_wr,
  input  logic               sync_clr,
  output logic [ADDR_W-1:0]  sin_addr,
  output logic [ADDR_W-1:0]  cos_addr,
  output logic               addr_valid,
  output logic               data_valid,
  output logic               wrap
);

  localparam int DITH_W = PHASE_W - ADDR_W;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [ADDR_W-1:0] QUARTER = {2'b01, {(ADDR_W-2){1'b0}}};

  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W-1:0] off_reg;
  logic [PHASE_W-1:0] acc;
  logic               acc_carry;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [PHASE_W:0]   acc_sum;
  logic [PHASE_W-1:0] dither;

  logic [PHASE_W-1:0] s1_phase;
  logic               s1_valid;
  logic               s1_wrap;
  logic [PHASE_W-1:0] s2_phase;
  logic               s2_valid;
  logic               s2_wrap;
  logic [ADDR_W-1:0]  s3_sin;

  // Valid semantics: a *_valid bit qualifies its stage's phase/address in the
  // same cycle; there is no backpressure, so a valid sample always advances.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign acc_sum = {1'b0, acc} + {1'b0, freq_reg};
  assign s3_sin  = s2_phase[PHASE_W-1 -: ADDR_W];

  always_comb begin
    dither = '0;
    if (DITHER_EN != 0) dither[DITH_W-1:0] = lfsr[DITH_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_reg   <= '0;
      off_reg    <= '0;
      acc        <= '0;
      acc_carry  <= 1'b0;
      lfsr       <= LFSR_SEED;
      s1_phase   <= '0;
      s1_valid   <= 1'b0;
      s1_wrap    <= 1'b0;
      s2_phase   <= '0;
      s2_valid   <= 1'b0;
      s2_wrap    <= 1'b0;
      sin_addr   <= '0;
      cos_addr   <= '0;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      if (freq_wr)  freq_reg <= freq_word;
      if (phase_wr) off_reg  <= phase_off;

      // acc_carry remembers that the current acc value was reached by an
      // overflow, so wrap travels with the first sample past the wrap point.
      if (sync_clr) begin
        acc       <= '0;
        acc_carry <= 1'b0;
        lfsr      <= LFSR_SEED;
      end else if (en) begin
        acc       <= acc_sum[PHASE_W-1:0];
        acc_carry <= acc_sum[PHASE_W];
        lfsr      <= {lfsr[14:0], lfsr_fb};
      end

      s1_valid <= en & ~sync_clr;
      if (en && !sync_clr) begin
        s1_phase <= acc;
        s1_wrap  <= acc_carry;
      end

      s2_valid <= s1_valid;
      s2_wrap  <= s1_valid & s1_wrap;
      if (s1_valid) s2_phase <= s1_phase + off_reg + dither;

      addr_valid <= s2_valid;
      wrap       <= s2_valid & s2_wrap;
      if (s2_valid) begin
        sin_addr <= s3_sin;
        cos_addr <= s3_sin + QUARTER;
      end

      data_valid <= addr_valid;
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: one undithered instance for address/valid/wrap
// sequences and one dithered instance for the LFSR behaviour.
module tb_nco_phase_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] freq_word;
  logic        freq_wr;
  logic [31:0] phase_off;
  logic        phase_wr;
  logic        sync_clr;

  logic [11:0] sin0, cos0, sin1, cos1;
  logic        av0, dv0, wr0, av1, dv1, wr1;

  int checks = 0;
  int errors = 0;
  logic [15:0] lfsr_m;

  nco_phase_gen #(.PHASE_W(32), .ADDR_W(12), .DITHER_EN(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .freq_word(freq_word), .freq_wr(freq_wr),
    .phase_off(phase_off), .phase_wr(phase_wr), .sync_clr(sync_clr),
    .sin_addr(sin0), .cos_addr(cos0), .addr_valid(av0), .data_valid(dv0), .wrap(wr0)
  );

  nco_phase_gen #(.PHASE_W(32), .ADDR_W(12), .DITHER_EN(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .freq_word(freq_word), .freq_wr(freq_wr),
    .phase_off(phase_off), .phase_wr(phase_wr), .sync_clr(sync_clr),
    .sin_addr(sin1), .cos_addr(cos1), .addr_valid(av1), .data_valid(dv1), .wrap(wr1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; freq_word = '0; freq_wr = 1'b0;
    phase_off = '0; phase_wr = 1'b0; sync_clr = 1'b0;
    tick(); tick();
    chk("rst_sin", 32'(sin0), 0);
    chk("rst_cos", 32'(cos0), 0);
    chk("rst_av", 32'(av0), 0);
    chk("rst_dv", 32'(dv0), 0);
    chk("rst_wrap", 32'(wr0), 0);
    chk("rst_lfsr", 32'(dut1.lfsr), 32'hACE1);

    // step 1 LSB of the address per sample
    rst = 1'b0;
    freq_word = 32'h0010_0000; freq_wr = 1'b1;
    tick();
    freq_wr = 1'b0; en = 1'b1;
    tick(); chk("lat_e1_av", 32'(av0), 0);
    tick(); chk("lat_e2_av", 32'(av0), 0);
    tick();
    chk("first_av", 32'(av0), 1);
    chk("first_sin", 32'(sin0), 0);
    chk("first_cos", 32'(cos0), 1024);
    chk("first_dv", 32'(dv0), 0);
    chk("first_wrap", 32'(wr0), 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("step_sin", 32'(sin0), 32'(k));
      chk("step_cos", 32'(cos0), 32'(1024 + k));
      chk("step_dv", 32'(dv0), 1);
    end

    // quarter-turn offset load while running
    phase_off = 32'h4000_0000; phase_wr = 1'b1;
    tick(); chk("off_e11_sin", 32'(sin0), 8);
    phase_wr = 1'b0;
    tick(); chk("off_e12_sin", 32'(sin0), 9);
    tick();
    chk("off_e13_sin", 32'(sin0), 1034);
    chk("off_e13_cos", 32'(cos0), 2058);
    chk("off_e13_wrap", 32'(wr0), 0);
    tick(); chk("off_e14_sin", 32'(sin0), 1035);

    // three-cycle enable gap
    en = 1'b0;
    tick(); chk("gap_e15_sin", 32'(sin0), 1036); chk("gap_e15_av", 32'(av0), 1);
    tick(); chk("gap_e16_sin", 32'(sin0), 1037); chk("gap_e16_av", 32'(av0), 1);
    tick(); chk("gap_e17_av", 32'(av0), 0); chk("gap_e17_sin", 32'(sin0), 1037);
    en = 1'b1;
    tick(); chk("gap_e18_av", 32'(av0), 0); chk("gap_e18_sin", 32'(sin0), 1037);
    tick(); chk("gap_e19_av", 32'(av0), 0);
    tick(); chk("gap_e20_av", 32'(av0), 1); chk("gap_e20_sin", 32'(sin0), 1038);
    tick(); chk("gap_e21_sin", 32'(sin0), 1039);

    // sync clear together with a new frequency and zero offset
    en = 1'b0; sync_clr = 1'b1; freq_word = 32'h0020_0000; freq_wr = 1'b1;
    phase_off = 32'h0; phase_wr = 1'b1;
    tick(); chk("clr_drain1", 32'(sin0), 1040);
    sync_clr = 1'b0; freq_wr = 1'b0; phase_wr = 1'b0; en = 1'b1;
    tick(); chk("clr_drain2", 32'(sin0), 1041); chk("clr_drain2_av", 32'(av0), 1);
    tick(); chk("clr_bubble_av", 32'(av0), 0);
    tick(); chk("clr_first_av", 32'(av0), 1); chk("clr_first_sin", 32'(sin0), 0);
    chk("clr_first_cos", 32'(cos0), 1024);
    tick(); chk("clr_s2", 32'(sin0), 2);
    tick(); chk("clr_s4", 32'(sin0), 4);

    // half-turn step: alternating addresses and wrap pulses
    en = 1'b0; sync_clr = 1'b1; freq_word = 32'h8000_0000; freq_wr = 1'b1;
    tick(); chk("half_drain1", 32'(sin0), 6);
    sync_clr = 1'b0; freq_wr = 1'b0; en = 1'b1;
    tick(); chk("half_drain2", 32'(sin0), 8);
    tick(); chk("half_bubble_av", 32'(av0), 0); chk("half_bubble_wrap", 32'(wr0), 0);
    tick();
    chk("half_first_sin", 32'(sin0), 0);
    chk("half_first_wrap", 32'(wr0), 0);
    chk("half_first_dv", 32'(dv0), 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("half_sin", 32'(sin0), (k % 2 == 1) ? 32'd2048 : 32'd0);
      chk("half_cos", 32'(cos0), (k % 2 == 1) ? 32'd3072 : 32'd1024);
      chk("half_wrap", 32'(wr0), (k % 2 == 1) ? 32'd0 : 32'd1);
      chk("half_dv", 32'(dv0), 1);
    end

    // asynchronous reset during continuous enable
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_av", 32'(av0), 0);
    chk("mid_rst_sin", 32'(sin0), 0);
    chk("mid_rst_cos", 32'(cos0), 0);
    chk("mid_rst_dv", 32'(dv0), 0);
    chk("mid_rst_wrap", 32'(wr0), 0);
    tick();
    rst = 1'b0;
    tick(); chk("post_rst_e1_av", 32'(av0), 0);
    tick(); chk("post_rst_e2_av", 32'(av0), 0);
    tick();
    chk("post_rst_av", 32'(av0), 1);
    chk("post_rst_sin", 32'(sin0), 0);
    chk("post_rst_cos", 32'(cos0), 1024);

    // dithered instance with zero frequency: LFSR sequence and address stay at 0
    en = 1'b0; sync_clr = 1'b1;
    tick(); chk("dith_seed", 32'(dut1.lfsr), 32'hACE1);
    sync_clr = 1'b0; en = 1'b1;
    lfsr_m = 16'hACE1;
    for (int k = 0; k < 20; k++) begin
      tick();
      lfsr_m = lfsr_step(lfsr_m);
      chk("dith_lfsr", 32'(dut1.lfsr), 32'(lfsr_m));
      chk("dith_sin", 32'(sin1), 0);
    end
    chk("dith_cos", 32'(cos1), 1024);
    chk("dith_av", 32'(av1), 1);
    en = 1'b0;
    tick(); chk("dith_hold", 32'(dut1.lfsr), 32'(lfsr_m));
    tick(); chk("dith_hold2", 32'(dut1.lfsr), 32'(lfsr_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
